cmd_trace_buf: RTL and testbench

Event trace buffer that sits directly downstream of `cmd_gen`. It watches the command-FSM outputs (`cmd_type`, `clk_cnt`, `stage1..stage4`) and records a timestamped entry whenever the stage vector or command type changes. Entries are buffered in a small first-word-fall-through FIFO and drained through a valid/ready port. A sticky overflow flag and a saturating drop counter report events lost while the FIFO is full.

---
 rtl/cmd_trace_buf.sv | 84 ++++++++
 tb/tb_cmd_trace_buf.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cmd_trace_buf.sv
// Timestamped event trace buffer for cmd_gen outputs: logs changes of stage vector/command
// type into a first-word-fall-through FIFO drained through a valid/ready port.
module cmd_trace_buf #(
   parameter int g_depth          = 8,
   parameter int g_drop_cnt_width = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   cmd_type,
   input  logic [15:0]                  clk_cnt,
   input  logic                         stage1,
   input  logic                         stage2,
   input  logic                         stage3,
   input  logic                         stage4,
   input  logic                         capture_en,
   input  logic                         clear_ovf,
   output logic [27:0]                  ev_data,
   output logic                         ev_valid,
   input  logic                         ev_ready,
   output logic [$clog2(g_depth):0]     ev_level,
   output logic                         overflow,
   output logic [g_drop_cnt_width-1:0]  drop_cnt
);

   localparam int PW = $clog2(g_depth);
   localparam int LW = PW + 1;

   logic [27:0]   mem [g_depth];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic [3:0]    stages, stages_q;
   logic [7:0]    cmd_q;
   logic          event_det, push, pop, full, wr_en, drop;

   assign stages    = {stage4, stage3, stage2, stage1};
   assign event_det = (stages != stages_q) || (cmd_type != cmd_q);
   assign push      = event_det && capture_en;
   assign pop       = (level != '0) && ev_ready;
   assign full      = (level == LW'(g_depth));
   // A pop frees the head slot at the same edge, so a full FIFO still accepts the push.
   assign wr_en     = push && (!full || pop);
   assign drop      = push && full && !pop;

   assign ev_valid = (level != '0);
   assign ev_level = level;
   assign ev_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         mem      <= '{default: '0};
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         stages_q <= '0;
         cmd_q    <= '0;
      end else begin
         stages_q <= stages;
         cmd_q    <= cmd_type;
         if (wr_en) begin
            mem[wr_ptr] <= {stages, cmd_type, clk_cnt};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !pop)      level <= level + 1'b1;
         else if (pop && !wr_en) level <= level - 1'b1;
      end
   end

   // A drop in the clearing cycle wins and counts as the first drop after the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clear_ovf)              drop_cnt <= g_drop_cnt_width'(1);
         else if (drop_cnt != '1)    drop_cnt <= drop_cnt + 1'b1;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_cmd_trace_buf.sv
// Directed bench for cmd_trace_buf: queue-based reference model checked every cycle,
// plus literal expectations at the test-plan milestones.
module tb_cmd_trace_buf;

   localparam int DEPTH = 8;
   localparam int DCW   = 8;

   logic        clk = 1'b0;
   logic        rst, capture_en, clear_ovf, ev_ready;
   logic [7:0]  cmd_type;
   logic [15:0] clk_cnt;
   logic        stage1, stage2, stage3, stage4;
   logic [27:0] ev_data;
   logic        ev_valid, overflow;
   logic [3:0]  ev_level;
   logic [DCW-1:0] drop_cnt;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   cmd_trace_buf #(.g_depth(DEPTH), .g_drop_cnt_width(DCW)) dut (
      .clk(clk), .rst(rst), .cmd_type(cmd_type), .clk_cnt(clk_cnt),
      .stage1(stage1), .stage2(stage2), .stage3(stage3), .stage4(stage4),
      .capture_en(capture_en), .clear_ovf(clear_ovf),
      .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_level(ev_level), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: FIFO as a queue, event = any change of {stages, cmd} from last cycle.
   logic [27:0] mq[$];
   logic [11:0] m_prev;
   logic        m_ovf;
   int unsigned m_dcnt;
   bit          started = 0;

   always @(posedge clk) begin
      logic [11:0] cur;
      if (rst) begin
         mq.delete();
         m_prev = '0;
         m_ovf = 0;
         m_dcnt = 0;
         started = 1;
      end else if (started) begin
         cur = {stage4, stage3, stage2, stage1, cmd_type};
         if (mq.size() != 0 && ev_ready) void'(mq.pop_front());
         if (clear_ovf) begin
            m_ovf = 0;
            m_dcnt = 0;
         end
         if (cur != m_prev && capture_en) begin
            if (mq.size() < DEPTH) mq.push_back({cur, clk_cnt});
            else begin
               m_ovf = 1;
               if (m_dcnt < (1 << DCW) - 1) m_dcnt++;
            end
         end
         m_prev = cur;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("cyc_valid", ev_valid, mq.size() != 0);
         chk("cyc_level", ev_level, mq.size());
         chk("cyc_overflow", overflow, m_ovf);
         chk("cyc_drop_cnt", drop_cnt, m_dcnt);
         if (mq.size() != 0) chk("cyc_data", ev_data, mq[0]);
      end
   end

   // Inputs change 2 time units after the rising edge; clk_cnt free-runs like cmd_gen's.
   task automatic step();
      @(posedge clk);
      #2;
      clk_cnt = clk_cnt + 16'd1;
   endtask

   initial begin
      rst = 1; capture_en = 1; clear_ovf = 0; ev_ready = 0;
      cmd_type = '0; clk_cnt = '0; {stage4, stage3, stage2, stage1} = '0;
      step(); step();
      chk("rst_valid", ev_valid, 0);
      chk("rst_level", ev_level, 0);
      chk("rst_data", ev_data, 0);
      rst = 0;

      repeat (10) step();
      chk("idle_valid", ev_valid, 0);
      chk("idle_level", ev_level, 0);

      cmd_type = 8'h5A; stage1 = 1; clk_cnt = 16'h0100;
      step();
      chk("first_valid", ev_valid, 1);
      chk("first_data", ev_data, 28'h15A0100);
      ev_ready = 1;
      step();
      ev_ready = 0;
      chk("pop_valid", ev_valid, 0);
      chk("pop_level", ev_level, 0);

      for (int i = 0; i < 8; i++) begin
         cmd_type = 8'h10 + 8'(i);
         step();
      end
      chk("full_level", ev_level, 8);
      cmd_type = 8'h20; step();
      cmd_type = 8'h21; step();
      chk("ovf_set", overflow, 1);
      chk("drop_two", drop_cnt, 2);

      cmd_type = 8'h30; ev_ready = 1;
      step();
      ev_ready = 0;
      chk("fullpop_level", ev_level, 8);
      chk("fullpop_drop", drop_cnt, 2);
      chk("fullpop_head", ev_data[23:16], 8'h11);

      ev_ready = 1;
      repeat (8) step();
      ev_ready = 0;
      chk("drained_level", ev_level, 0);

      capture_en = 0;
      for (int i = 0; i < 5; i++) begin
         stage2 = ~stage2;
         step();
      end
      chk("nocap_level", ev_level, 0);
      capture_en = 1;
      step();
      chk("enable_nochange", ev_level, 0);

      for (int i = 0; i < 8; i++) begin
         cmd_type = 8'h40 + 8'(i);
         step();
      end
      cmd_type = 8'h50; clear_ovf = 1;
      step();
      clear_ovf = 0;
      chk("clr_drop_ovf", overflow, 1);
      chk("clr_drop_cnt", drop_cnt, 1);
      clear_ovf = 1;
      step();
      clear_ovf = 0;
      chk("clr_ovf", overflow, 0);
      chk("clr_cnt", drop_cnt, 0);

      ev_ready = 1;
      repeat (3) step();
      ev_ready = 0;
      chk("five_level", ev_level, 5);
      rst = 1;
      step();
      rst = 0;
      chk("midrst_level", ev_level, 0);
      chk("midrst_valid", ev_valid, 0);
      chk("midrst_ovf", overflow, 0);
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
